bit_symbol_packer: RTL and testbench
====================================

# bit_symbol_packer

Parametrised serial-to-parallel symbol packer for the 2.4 GHz Zigbee transmitter. It accepts one PPDU bit per handshake, groups consecutive bits into SYMBOL_WIDTH-bit symbols in a selectable bit order, and zero-pads the final partial symbol of a frame. Completed symbols are buffered in a small FIFO and delivered over a valid/ready interface to the symbol-to-chip spreader. Backpressure propagates to the bit source, so no data is lost.

## Interface
- SYMBOL_WIDTH, 4: bits per symbol; legal range 2..16.
- FIFO_DEPTH, 4: symbol FIFO entries; power of two, at least 2.
- LSB_FIRST, 1: 1 = first received bit lands in symbol bit 0 (802.15.4 order); 0 = first received bit lands in bit SYMBOL_WIDTH-1.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_clear  in  1  synchronous flush; drops the partial symbol and all FIFO contents.
- i_valid  in  1  bit-side valid.
- i_data  in  1  serial data bit.
- i_last  in  1  marks the last bit of a frame; qualified by i_valid.
- o_ready  out  1  bit-side ready.
- o_symbol  out  SYMBOL_WIDTH  head-of-FIFO symbol.
- o_symbol_valid  out  1  o_symbol is valid.
- i_symbol_ready  in  1  downstream accepts the symbol.
- o_symbol_last  out  1  head symbol is the last symbol of its frame.
- o_symbol_pad  out  1  head symbol was zero-padded.

## Operation
- A bit is accepted when i_valid && o_ready. A symbol is popped when o_symbol_valid && i_symbol_ready.
- The accumulator holds a SYMBOL_WIDTH shift register and a bit counter with range 0..SYMBOL_WIDTH-1 and width max(1, $clog2(SYMBOL_WIDTH)).
- Bit placement:
  - LSB_FIRST=1: shift right and insert at the MSB.
  - LSB_FIRST=0: shift left and insert at the LSB.
- Close conditions: an accepted bit closes the symbol when the counter is SYMBOL_WIDTH-1, or when i_last=1.
- On close:
  - The final symbol is pushed into the FIFO with flags last = i_last and pad = (counter != SYMBOL_WIDTH-1).
  - The counter returns to 0.
  - The shift register is cleared.
- Padding: unfilled positions are 0.
  - LSB_FIRST=1: the k received bits occupy bits [k-1:0].
  - LSB_FIRST=0: the k received bits occupy bits [W-1:W-k].
- Frame state:
  - IDLE (counter==0) moves to FILL on an accepted bit that does not close the symbol.
  - FILL returns to IDLE on close.
- o_ready = !fifo_full. This is a registered full flag, so a same-cycle pop does not raise ready.
- i_clear has priority over accept and pop in the same cycle. Next cycle: counter 0, shift register 0, FIFO empty.
- Reset values: o_ready 1, o_symbol_valid 0, o_symbol 0, o_symbol_last 0, o_symbol_pad 0.
- Reset mid-frame discards everything; there is no partial output.
- i_last with a full symbol (counter==W-1) gives last=1, pad=0.
- i_last on the first bit gives a single-bit symbol with pad=1.

## Timing
- Latency: closing bit accepted in cycle N gives o_symbol_valid=1 in cycle N+1 if the FIFO was empty. The FIFO is show-ahead and its outputs are registered.
- Throughput: one bit per cycle. The sustained output rate is one symbol per SYMBOL_WIDTH cycles.
- The FIFO is never written when full, because o_ready is low. A simultaneous push and pop at non-full keeps the occupancy constant.
- o_symbol, o_symbol_last and o_symbol_pad are stable while o_symbol_valid=1 and i_symbol_ready=0.
- o_ready deasserts in the cycle after the FIFO_DEPTH-th unpopped symbol is pushed. It reasserts in the cycle after the next pop.

## Structure
- Package zigbee_tx_pkg holds:
  - the symbol-entry struct sym_entry_t, containing symbol, last and pad, with width set by SYMBOL_WIDTH through a parameterised typedef in the module;
  - the IDLE/FILL enum pack_state_e;
  - the constant ZB_SYMBOL_WIDTH = 4.
- Sub-module sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/full/empty/clear ports. The packer instantiates it with WIDTH = SYMBOL_WIDTH+2.

## Test plan
- Default parameters, bits 1,0,1,1 with i_symbol_ready=1 -> o_symbol=4'b1101, last=0, pad=0, valid 1 cycle after the 4th bit.
- LSB_FIRST=0, same bits -> o_symbol=4'b1011.
- Frame of 6 bits 1,1,1,1,1,0 with i_last on the 6th -> symbols 4'hF (last=0, pad=0), then 4'b0001 (last=1, pad=1).
- i_symbol_ready=0 with a continuous bit stream, FIFO_DEPTH=4 -> o_ready low after the 16th bit is accepted. Then a single pop -> o_ready high 1 cycle later, and the first symbol is intact.
- i_clear asserted after 2 bits with 1 symbol queued -> o_symbol_valid=0 next cycle. The next 4 bits produce a clean symbol with pad=0.
- Async reset mid-frame, with 3 bits in and 2 symbols queued -> all outputs at reset values immediately, o_ready=1. The next frame packs correctly from bit 0.

Source files
------------

// File: rtl/zigbee_tx_pkg.sv
// Shared types and constants for the Zigbee transmit datapath.
// The symbol width used by the 2.4 GHz PHY is ZB_SYMBOL_WIDTH.
package zigbee_tx_pkg;

  localparam int ZB_SYMBOL_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  // Default-width entry; modules with other widths declare their own.
  typedef struct packed {
    logic [ZB_SYMBOL_WIDTH-1:0] symbol;
    logic                       last;
    logic                       pad;
  } sym_entry_t;

  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_symbol_packer_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags and a
// synchronous flush. The head entry reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage holds data only; validity is tracked by the control flags.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/bit_symbol_packer.sv
// Serial-to-parallel symbol packer: groups PPDU bits into symbols, zero-pads
// the last partial symbol of a frame and queues symbols for the spreader.
module bit_symbol_packer
  import zigbee_tx_pkg::*;
#(
  parameter int SYMBOL_WIDTH = ZB_SYMBOL_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic                    i_data,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic [SYMBOL_WIDTH-1:0] o_symbol,
  output logic                    o_symbol_valid,
  input  logic                    i_symbol_ready,
  output logic                    o_symbol_last,
  output logic                    o_symbol_pad
);

  localparam int CNT_W = cnt_width(SYMBOL_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_WIDTH - 1);

  typedef struct packed {
    logic [SYMBOL_WIDTH-1:0] symbol;
    logic                    last;
    logic                    pad;
  } sym_word_t;

  localparam int ENTRY_W = $bits(sym_word_t);

  pack_state_e             r_state;
  pack_state_e             w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [SYMBOL_WIDTH-1:0] r_shift;
  logic [SYMBOL_WIDTH-1:0] w_shift_nxt;
  logic [SYMBOL_WIDTH-1:0] w_base;
  logic [SYMBOL_WIDTH-1:0] w_shift_in;

  logic                    w_accept;
  logic                    w_close;
  logic                    w_push;
  sym_word_t               w_entry;
  sym_word_t               w_head;
  logic [ENTRY_W-1:0]      w_fifo_dout;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;

  // Move the k received bits of a short symbol to their final positions.
  function automatic logic [SYMBOL_WIDTH-1:0] align_symbol(
    input logic [SYMBOL_WIDTH-1:0] sh,
    input logic [CNT_W-1:0]        cnt
  );
    logic [CNT_W-1:0] gap;
    gap = CNT_LAST - cnt;
    if (LSB_FIRST != 0) begin
      return sh >> gap;
    end else begin
      return sh << gap;
    end
  endfunction

  assign o_ready  = ~w_full;
  assign w_accept = i_valid & o_ready;
  assign w_close  = w_accept & ((r_cnt == CNT_LAST) | i_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_entry     = '0;
    // A fresh symbol always starts from an all-zero register.
    w_base      = (r_state == IDLE) ? '0 : r_shift;
    w_shift_in  = (LSB_FIRST != 0) ? {i_data, w_base[SYMBOL_WIDTH-1:1]}
                                   : {w_base[SYMBOL_WIDTH-2:0], i_data};

    if (i_clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end else if (w_accept) begin
      if (w_close) begin
        w_push         = 1'b1;
        w_entry.symbol = align_symbol(w_shift_in, r_cnt);
        w_entry.last   = i_last;
        w_entry.pad    = (r_cnt != CNT_LAST);
        w_state_nxt    = IDLE;
        w_cnt_nxt      = '0;
        w_shift_nxt    = '0;
      end else begin
        w_state_nxt = FILL;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_shift_nxt = w_shift_in;
      end
    end
  end

  assign w_pop = o_symbol_valid & i_symbol_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head         = w_fifo_dout;
  assign o_symbol_valid = ~w_empty;
  assign o_symbol       = w_head.symbol;
  assign o_symbol_last  = w_head.last;
  assign o_symbol_pad   = w_head.pad;

endmodule

// File: tb/tb_bit_symbol_packer.sv
// Bench for bit_symbol_packer: an LSB-first and an MSB-first instance share
// one stimulus stream and are checked against a queue-based frame model.
module tb_bit_symbol_packer;

  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic valid = 1'b0;
  logic data = 1'b0;
  logic last = 1'b0;
  logic sym_ready = 1'b0;

  logic         rdy_a, vld_a, last_a, pad_a;
  logic [W-1:0] sym_a;
  logic         rdy_b, vld_b, last_b, pad_b;
  logic [W-1:0] sym_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_symbol_packer #(.SYMBOL_WIDTH(W), .FIFO_DEPTH(D), .LSB_FIRST(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid),
    .i_data(data), .i_last(last), .o_ready(rdy_a), .o_symbol(sym_a),
    .o_symbol_valid(vld_a), .i_symbol_ready(sym_ready),
    .o_symbol_last(last_a), .o_symbol_pad(pad_a)
  );

  bit_symbol_packer #(.SYMBOL_WIDTH(W), .FIFO_DEPTH(D), .LSB_FIRST(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid),
    .i_data(data), .i_last(last), .o_ready(rdy_b), .o_symbol(sym_b),
    .o_symbol_valid(vld_b), .i_symbol_ready(sym_ready),
    .o_symbol_last(last_b), .o_symbol_pad(pad_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: frame bits collect in a list; each complete or closing group
  // becomes a queued symbol built by placing received bit i directly.
  typedef struct {
    logic [W-1:0] lsb;
    logic [W-1:0] msb;
    logic         lst;
    logic         pad;
  } ent_t;

  ent_t mq[$];
  logic fbits[$];
  logic m_ready = 1'b1;

  initial forever begin
    ent_t e;
    bit   acc;
    bit   pop;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      fbits.delete();
      m_ready = 1'b1;
    end else if (clear) begin
      mq.delete();
      fbits.delete();
      m_ready = 1'b1;
    end else begin
      acc = valid && m_ready;
      pop = (mq.size() != 0) && sym_ready;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        fbits.push_back(data);
        if (fbits.size() == W || last) begin
          e.lsb = '0;
          e.msb = '0;
          for (int i = 0; i < fbits.size(); i++) begin
            e.lsb[i]         = fbits[i];
            e.msb[W - 1 - i] = fbits[i];
          end
          e.lst = last;
          e.pad = (fbits.size() < W);
          mq.push_back(e);
          fbits.delete();
        end
      end
      m_ready = (mq.size() < D);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("ready_a", rdy_a, m_ready);
      chk("ready_b", rdy_b, m_ready);
      chk("valid_a", vld_a, (mq.size() != 0));
      chk("valid_b", vld_b, (mq.size() != 0));
      if (mq.size() != 0) begin
        chk("symbol_a", sym_a, mq[0].lsb);
        chk("symbol_b", sym_b, mq[0].msb);
        chk("last_a", last_a, mq[0].lst);
        chk("last_b", last_b, mq[0].lst);
        chk("pad_a", pad_a, mq[0].pad);
        chk("pad_b", pad_b, mq[0].pad);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic l);
    int   n;
    logic took;
    valid = 1'b1;
    data  = d;
    last  = l;
    n     = 0;
    do begin
      took = rdy_a;
      tick();
      n++;
    end while (!took && n < 100);
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL send_timeout: bit not accepted within %0d cycles", n);
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, rdy_a, 1'b1);
    chk({tag, "_valid"}, vld_a, 1'b0);
    chk({tag, "_symbol"}, sym_a, 4'h0);
    chk({tag, "_last"}, last_a, 1'b0);
    chk({tag, "_pad"}, pad_a, 1'b0);
    chk({tag, "_valid_b"}, vld_b, 1'b0);
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  pre;
    pat = 16'h5A93;
    pre = 8'b1110_1001;

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic packing in both bit orders.
    sym_ready = 1'b1;
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
    chk("t1_valid", vld_a, 1'b1);
    chk("t1_sym_lsb", sym_a, 4'b1101);
    chk("t1_sym_msb", sym_b, 4'b1011);
    chk("t1_last", last_a, 1'b0);
    chk("t1_pad", pad_a, 1'b0);
    tick(); tick();

    // Last flag on the very first bit.
    send_bit(1, 1);
    chk("t2_sym_lsb", sym_a, 4'b0001);
    chk("t2_sym_msb", sym_b, 4'b1000);
    chk("t2_last", last_a, 1'b1);
    chk("t2_pad", pad_a, 1'b1);
    tick();

    // Six-bit frame: one full symbol then a padded tail.
    sym_ready = 1'b0;
    send_bit(1, 0); send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
    chk("t3_first_sym", sym_a, 4'hF);
    send_bit(1, 0); send_bit(0, 1);
    chk("t3_first_last", last_a, 1'b0);
    chk("t3_first_pad", pad_a, 1'b0);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    chk("t3_tail_lsb", sym_a, 4'b0001);
    chk("t3_tail_msb", sym_b, 4'b1000);
    chk("t3_tail_last", last_a, 1'b1);
    chk("t3_tail_pad", pad_a, 1'b1);
    sym_ready = 1'b1;
    tick();
    chk("t3_drained", vld_a, 1'b0);

    // Backpressure: fill the FIFO with 16 bits, then release one slot.
    sym_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_bit(pat[i], 0);
    chk("t4_ready_before_full", rdy_a, 1'b1);
    send_bit(pat[15], 0);
    chk("t4_ready_low", rdy_a, 1'b0);
    valid = 1'b1; data = 1'b1; last = 1'b1;
    tick(); tick(); tick();
    chk("t4_ready_held_low", rdy_a, 1'b0);
    chk("t4_head_lsb", sym_a, 4'h3);
    chk("t4_head_msb", sym_b, 4'hC);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    chk("t4_ready_back", rdy_a, 1'b1);
    tick();
    valid = 1'b0; last = 1'b0;
    chk("t4_full_again", rdy_a, 1'b0);
    sym_ready = 1'b1;
    repeat (6) tick();
    chk("t4_drained", vld_a, 1'b0);

    // Flush with a queued symbol and a partial one.
    sym_ready = 1'b0;
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
    send_bit(1, 0); send_bit(1, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_valid_cleared", vld_a, 1'b0);
    chk("t5_ready", rdy_a, 1'b1);
    sym_ready = 1'b1;
    send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(0, 0);
    chk("t5_valid", vld_a, 1'b1);
    chk("t5_sym_lsb", sym_a, 4'b0010);
    chk("t5_sym_msb", sym_b, 4'b0100);
    chk("t5_pad", pad_a, 1'b0);
    tick(); tick();

    // Asynchronous reset mid-frame with two symbols queued.
    sym_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(pre[i], 0);
    send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
    chk("t6_queued", vld_a, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    sym_ready = 1'b1;
    send_bit(1, 0); send_bit(0, 0); send_bit(0, 0); send_bit(0, 1);
    chk("t6_sym_lsb", sym_a, 4'b0001);
    chk("t6_sym_msb", sym_b, 4'b1000);
    chk("t6_last", last_a, 1'b1);
    chk("t6_pad", pad_a, 1'b0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
